bht_gshare: RTL and testbench
=============================

Name: bht_gshare

Overview:
- Parametrised successor to the per-PC 2-bit branch history table.
- Predicts direction for INSTR_PER_FETCH lanes using CTR_BITS-wide saturating counters, indexed by PC XOR a speculative global history register (GHR).
- Restores the GHR on mispredicts and re-initialises its storage with a sequential sweep FSM.
- Sits in the frontend beside the BTB: fed by the fetch vpc and by execute-stage branch resolution.

Parameters:
- VLEN, 64, virtual address width
- INSTR_PER_FETCH, 2, prediction lanes per fetch block (power of 2, >=1)
- RVC, 1, compressed ISA enabled (OFFSET = 1 if RVC else 2)
- NR_ENTRIES, 1024, total counters; NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH, ROW_BITS = clog2(NR_ROWS)
- CTR_BITS, 2, saturating counter width (>=2)
- HIST_BITS, 8, GHR length; elaboration error if HIST_BITS > ROW_BITS
- DEBUG_EN, 1, suppress training while in debug mode

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_bp_i  in  1  invalidate all entries and clear GHR
- debug_mode_i  in  1  hart in debug mode
- vpc_i  in  VLEN  fetch virtual PC
- lookup_valid_i  in  1  fetch block consumed this cycle
- spec_branch_i  in  1  consumed block contains a predicted conditional branch
- spec_taken_i  in  1  direction predicted for that branch
- ghr_o  out  HIST_BITS  current speculative GHR (fetch attaches it to each branch)
- upd_valid_i  in  1  resolved conditional branch
- upd_pc_i  in  VLEN  its PC
- upd_taken_i  in  1  resolved direction
- upd_mispredict_i  in  1  direction was mispredicted
- upd_ghr_i  in  HIST_BITS  GHR snapshot captured at its prediction
- pred_valid_o  out  INSTR_PER_FETCH  per-lane entry valid
- pred_taken_o  out  INSTR_PER_FETCH  per-lane counter MSB
- init_busy_o  out  1  sweep in progress

Behaviour:
- Indexing:
  - lane = pc[LANE_BITS+OFFSET-1:OFFSET], where LANE_BITS = clog2(INSTR_PER_FETCH); lane = 0 when INSTR_PER_FETCH == 1.
  - row = pc[ROW_BITS+LANE_BITS+OFFSET-1 : LANE_BITS+OFFSET] XOR zero-extended GHR.
  - Lookup uses the registered GHR value (ghr_q); update uses upd_ghr_i.
- Prediction:
  - Combinational from vpc_i and ghr_q. Lane i outputs entry[row][i].valid and counter MSB.
  - A same-cycle update is not visible; it appears from the next cycle.
- Storage: flop array, no reset on data. Entry = {valid, ctr[CTR_BITS-1:0]}. Init value = {0, 1<<(CTR_BITS-1)} (weakly taken).
- FSM states INIT and RUN:
  - rst_i forces INIT with row pointer 0 and ghr 0.
  - INIT writes the init value to all lanes of row[ptr], one row per cycle. The last row (ptr = NR_ROWS-1) moves to RUN next cycle.
  - flush_bp_i in any state causes INIT with ptr = 0, so a flush mid-sweep restarts the sweep.
  - In INIT: init_busy_o = 1, pred_valid_o = 0, pred_taken_o = 0, ghr held at 0, all updates and lookups ignored.
  - INIT lasts exactly NR_ROWS cycles after reset deassertion or after the last flush.
- Reset values: pred_valid_o = 0, pred_taken_o = 0, ghr_o = 0, init_busy_o = 1.
- Training, in RUN only, when upd_valid_i and not (DEBUG_EN and debug_mode_i):
  - Entry valid is set to 1.
  - Counter increments if taken and decrements if not taken, saturating at 0 and 2^CTR_BITS-1.
  - Written at the clock edge.
- GHR, in RUN only, priority order:
  - Recovery: upd_valid_i and upd_mispredict_i gives ghr <= {upd_ghr_i[HIST_BITS-2:0], upd_taken_i}. Recovery is performed even in debug mode.
  - Shift: otherwise, lookup_valid_i and spec_branch_i gives ghr <= {ghr[HIST_BITS-2:0], spec_taken_i}. The shift is dropped in a recovery cycle.
  - Otherwise the GHR holds.
- Simultaneous events: flush beats update, recovery and shift. An update and a lookup to the same entry in one cycle are legal; the prediction returns the pre-update value.

Test Plan (defaults; ghr = 0 unless stated; vpc 0x1000 maps to row 0, lane 0):
1. Release rst_i → init_busy_o = 1 for exactly 512 cycles with pred_valid_o = 0; then vpc 0x1000 gives pred_valid_o[0] = 0, pred_taken_o[0] = 1.
2. Train pc 0x1000 not-taken three times → counter 10, 01, 00, 00 and pred = valid 1, taken 0. Two taken updates → 01 then 10, taken = 1. With CTR_BITS = 3, eight taken updates saturate at 111.
3. Lookups with spec_branch_i = 1 and spec_taken_i sequence 1, 0, 1 → ghr_o = 0x05. A lookup with spec_branch_i = 0 leaves ghr_o unchanged.
4. Same cycle: mispredict upd_ghr_i = 0x3C, upd_taken_i = 1, plus a lookup shift of 0 → ghr_o = 0x79. Then with ghr = 0x01, vpc 0x1000 reads row 1; entry trained at pc 0x1004 with upd_ghr_i = 0 is hit.
5. debug_mode_i = 1 with a mispredicted update → counter and valid unchanged, but the GHR is restored.
6. flush_bp_i at sweep row 100 → sweep restarts, 512 further busy cycles. An update in the same cycle as flush_bp_i is dropped. After flush, trained entries read valid 0, taken 1, and ghr_o = 0.

Source files
------------

// File: rtl/bht_gshare.sv
// Gshare direction predictor: per-lane saturating counters indexed by PC XOR a
// speculative global history register, with a row-sweep initialiser after reset/flush.
module bht_gshare #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned RVC             = 1,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned HIST_BITS       = 8,
    parameter int unsigned DEBUG_EN        = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       lookup_valid_i,
    input  logic                       spec_branch_i,
    input  logic                       spec_taken_i,
    output logic [HIST_BITS-1:0]       ghr_o,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic                       upd_taken_i,
    input  logic                       upd_mispredict_i,
    input  logic [HIST_BITS-1:0]       upd_ghr_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic                       init_busy_o
);
    localparam int unsigned OFFSET    = (RVC != 0) ? 1 : 2;
    localparam int unsigned LANE_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 0;
    localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
    localparam int unsigned ROW_LSB   = LANE_BITS + OFFSET;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(NR_ROWS - 1);
    localparam logic [ROW_BITS-1:0] ROW_ONE    = ROW_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX    = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ONE    = CTR_BITS'(1);
    localparam logic [CTR_BITS:0]   INIT_ENTRY = {1'b0, 1'b1, {(CTR_BITS-1){1'b0}}};

    generate
        if (HIST_BITS > ROW_BITS) begin : g_bad_hist
            $error("bht_gshare: HIST_BITS must not exceed ROW_BITS");
        end
        if (HIST_BITS < 2 || CTR_BITS < 2) begin : g_bad_width
            $error("bht_gshare: HIST_BITS and CTR_BITS must be at least 2");
        end
    endgenerate

    logic [0:0]           state_q;
    logic [ROW_BITS-1:0]  ptr_q;
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_next;
    logic                 run;
    logic                 init_we;
    logic                 train_en;
    logic [ROW_BITS-1:0]  rd_row;
    logic [ROW_BITS-1:0]  upd_row;
    logic [LANE_W-1:0]    upd_lane;
    logic                 unused_bits;

    assign run      = (state_q == ST_RUN);
    assign init_we  = (state_q == ST_INIT);
    assign train_en = run && upd_valid_i && !flush_bp_i
                      && !((DEBUG_EN != 0) && debug_mode_i);

    assign rd_row  = vpc_i[ROW_LSB +: ROW_BITS] ^ ROW_BITS'(ghr_q);
    assign upd_row = upd_pc_i[ROW_LSB +: ROW_BITS] ^ ROW_BITS'(upd_ghr_i);

    generate
        if (INSTR_PER_FETCH > 1) begin : g_lane_sel
            assign upd_lane = upd_pc_i[OFFSET +: LANE_W];
        end else begin : g_lane_zero
            assign upd_lane = '0;
        end
    endgenerate

    assign unused_bits = ^{vpc_i, upd_pc_i, upd_ghr_i[HIST_BITS-1]};

    // Recovery from a mispredict wins over the speculative shift of this cycle.
    always_comb begin
        ghr_next = ghr_q;
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_next = {upd_ghr_i[HIST_BITS-2:0], upd_taken_i};
        end else if (lookup_valid_i && spec_branch_i) begin
            ghr_next = {ghr_q[HIST_BITS-2:0], spec_taken_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else if (flush_bp_i) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ghr_q <= '0;
                    ptr_q <= ptr_q + ROW_ONE;
                    if (ptr_q == ROW_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    ghr_q <= ghr_next;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_lane
            logic [CTR_BITS:0]   mem [NR_ROWS];
            logic [CTR_BITS-1:0] upd_ctr;
            logic [CTR_BITS-1:0] upd_ctr_next;
            logic                rd_valid;
            logic                rd_msb;

            assign upd_ctr  = mem[upd_row][CTR_BITS-1:0];
            assign rd_valid = mem[rd_row][CTR_BITS];
            assign rd_msb   = mem[rd_row][CTR_BITS-1];

            always_comb begin
                upd_ctr_next = upd_ctr;
                if (upd_taken_i) begin
                    if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_ONE;
                end else begin
                    if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_ONE;
                end
            end

            // Data array carries no reset; the sweep establishes its contents.
            always_ff @(posedge clk_i) begin
                if (init_we) begin
                    mem[ptr_q] <= INIT_ENTRY;
                end else if (train_en && upd_lane == LANE_W'(gi)) begin
                    mem[upd_row] <= {1'b1, upd_ctr_next};
                end
            end

            assign pred_valid_o[gi] = run & rd_valid;
            assign pred_taken_o[gi] = run & rd_msb;
        end
    endgenerate

    assign ghr_o       = ghr_q;
    assign init_busy_o = ~run;
endmodule

// File: tb/tb_bht_gshare.sv
// Directed bench for bht_gshare: sweep length, counter training, GHR shift and
// recovery, debug suppression and flush restart; a CTR_BITS=3 copy checks wider saturation.
module tb_bht_gshare;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_bp_i;
    logic        debug_mode_i;
    logic [63:0] vpc_i;
    logic        lookup_valid_i;
    logic        spec_branch_i;
    logic        spec_taken_i;
    logic        upd_valid_i;
    logic [63:0] upd_pc_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
    logic [7:0]  upd_ghr_i;

    logic [7:0]  ghr_o, ghr3_o;
    logic [1:0]  pred_valid_o, pred_taken_o, pred_valid3_o, pred_taken3_o;
    logic        init_busy_o, init_busy3_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    bht_gshare u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
        .vpc_i(vpc_i), .lookup_valid_i(lookup_valid_i), .spec_branch_i(spec_branch_i),
        .spec_taken_i(spec_taken_i), .ghr_o(ghr_o), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .upd_mispredict_i(upd_mispredict_i),
        .upd_ghr_i(upd_ghr_i), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .init_busy_o(init_busy_o)
    );

    bht_gshare #(.CTR_BITS(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
        .vpc_i(vpc_i), .lookup_valid_i(lookup_valid_i), .spec_branch_i(spec_branch_i),
        .spec_taken_i(spec_taken_i), .ghr_o(ghr3_o), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .upd_mispredict_i(upd_mispredict_i),
        .upd_ghr_i(upd_ghr_i), .pred_valid_o(pred_valid3_o), .pred_taken_o(pred_taken3_o),
        .init_busy_o(init_busy3_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic taken, input logic mis,
                       input logic [7:0] g);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_taken_i      = taken;
        upd_mispredict_i = mis;
        upd_ghr_i        = g;
        tick();
        upd_valid_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic look(input logic br, input logic tk);
        lookup_valid_i = 1'b1;
        spec_branch_i  = br;
        spec_taken_i   = tk;
        tick();
        lookup_valid_i = 1'b0;
        spec_branch_i  = 1'b0;
        spec_taken_i   = 1'b0;
    endtask

    // Counts busy cycles until init_busy_o drops, noting any valid prediction seen.
    task automatic count_busy(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (init_busy_o && n < 2000) begin
            if (pred_valid_o != 2'b00 || pred_taken_o != 2'b00) saw_valid = 1'b1;
            n++;
            tick();
        end
    endtask

    initial begin
        int   n;
        logic sv;
        rst_i = 1'b1; flush_bp_i = 1'b0; debug_mode_i = 1'b0; vpc_i = 64'h1000;
        lookup_valid_i = 1'b0; spec_branch_i = 1'b0; spec_taken_i = 1'b0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_mispredict_i = 1'b0;
        upd_ghr_i = '0;
        tick(); tick();
        chk("reset_busy", init_busy_o, 1'b1);
        chk("reset_pred_valid", pred_valid_o, 2'b00);
        chk("reset_pred_taken", pred_taken_o, 2'b00);
        chk("reset_ghr", ghr_o, 8'h00);
        rst_i = 1'b0;

        // 1: sweep length and post-init state
        count_busy(n, sv);
        chk("init_cycles", n, 512);
        chk("init_no_pred", sv, 1'b0);
        chk("init3_done", init_busy3_o, 1'b0);
        chk("post_init_valid", pred_valid_o, 2'b00);
        chk("post_init_taken", pred_taken_o, 2'b11);
        chk("post_init_ghr", ghr_o, 8'h00);

        // 2: counter training at pc 0x1000 (row 0, lane 0)
        upd(64'h1000, 1'b0, 1'b0, 8'h00);
        chk("nt1_valid", pred_valid_o[0], 1'b1);
        chk("nt1_taken", pred_taken_o[0], 1'b0);
        upd(64'h1000, 1'b0, 1'b0, 8'h00);
        chk("nt2_taken", pred_taken_o[0], 1'b0);
        upd(64'h1000, 1'b0, 1'b0, 8'h00);
        chk("nt3_sat0_taken", pred_taken_o[0], 1'b0);
        upd(64'h1000, 1'b1, 1'b0, 8'h00);
        chk("t1_taken", pred_taken_o[0], 1'b0);
        upd(64'h1000, 1'b1, 1'b0, 8'h00);
        chk("t2_taken", pred_taken_o[0], 1'b1);
        chk("lane1_untouched", pred_valid_o[1], 1'b0);
        upd(64'h1000, 1'b1, 1'b0, 8'h00);
        upd(64'h1000, 1'b1, 1'b0, 8'h00);
        upd(64'h1000, 1'b0, 1'b0, 8'h00);
        chk("sat3_nt1_taken", pred_taken_o[0], 1'b1);
        upd(64'h1000, 1'b0, 1'b0, 8'h00);
        chk("sat3_nt2_taken", pred_taken_o[0], 1'b0);

        // CTR_BITS=3 copy at pc 0x1008 (row 2): 100 -> 111 saturated, then down
        vpc_i = 64'h1008;
        for (int i = 0; i < 8; i++) upd(64'h1008, 1'b1, 1'b0, 8'h00);
        chk("c3_t8_taken", pred_taken3_o[0], 1'b1);
        for (int i = 0; i < 3; i++) upd(64'h1008, 1'b0, 1'b0, 8'h00);
        chk("c3_nt3_taken", pred_taken3_o[0], 1'b1);
        upd(64'h1008, 1'b0, 1'b0, 8'h00);
        chk("c3_nt4_taken", pred_taken3_o[0], 1'b0);
        vpc_i = 64'h1000;

        // 3: speculative shifts
        look(1'b1, 1'b1);
        look(1'b1, 1'b0);
        look(1'b1, 1'b1);
        chk("ghr_shift_101", ghr_o, 8'h05);
        look(1'b0, 1'b1);
        chk("ghr_no_branch", ghr_o, 8'h05);

        // 4: recovery beats shift in the same cycle
        lookup_valid_i = 1'b1; spec_branch_i = 1'b1; spec_taken_i = 1'b0;
        upd(64'h2000, 1'b1, 1'b1, 8'h3C);
        lookup_valid_i = 1'b0; spec_branch_i = 1'b0;
        chk("ghr_recover", ghr_o, 8'h79);
        upd(64'h1004, 1'b1, 1'b1, 8'h00);
        chk("ghr_recover_01", ghr_o, 8'h01);
        chk("gshare_hit_valid", pred_valid_o[0], 1'b1);
        chk("gshare_hit_taken", pred_taken_o[0], 1'b1);
        vpc_i = 64'h1008;
        #1;
        chk("gshare_row3_miss", pred_valid_o, 2'b00);
        vpc_i = 64'h1000;

        // same-cycle update is not visible until the next cycle (row 1: 11 -> 10 -> 01)
        upd_valid_i = 1'b1; upd_pc_i = 64'h1004; upd_taken_i = 1'b0; upd_ghr_i = 8'h00;
        #1;
        chk("same_cycle_a", pred_taken_o[0], 1'b1);
        tick();
        chk("same_cycle_b", pred_taken_o[0], 1'b1);
        tick();
        upd_valid_i = 1'b0;
        chk("after_two_nt", pred_taken_o[0], 1'b0);

        // 5: debug mode blocks training but not recovery
        debug_mode_i = 1'b1;
        upd(64'h1004, 1'b1, 1'b1, 8'h0F);
        chk("debug_ghr", ghr_o, 8'h1F);
        upd(64'h1006, 1'b1, 1'b0, 8'h00);
        debug_mode_i = 1'b0;
        vpc_i = 64'h1078;
        #1;
        chk("debug_valid", pred_valid_o, 2'b01);
        chk("debug_taken", pred_taken_o, 2'b10);

        // 6: flush with a concurrent mispredict, then a flush at sweep row 100
        flush_bp_i = 1'b1;
        lookup_valid_i = 1'b1; spec_branch_i = 1'b1; spec_taken_i = 1'b1;
        upd(64'h1006, 1'b1, 1'b1, 8'h3C);
        flush_bp_i = 1'b0;
        lookup_valid_i = 1'b0; spec_branch_i = 1'b0; spec_taken_i = 1'b0;
        chk("flush_busy", init_busy_o, 1'b1);
        chk("flush_ghr", ghr_o, 8'h00);
        chk("flush_pred_valid", pred_valid_o, 2'b00);
        for (int i = 0; i < 100; i++) tick();
        chk("mid_sweep_busy", init_busy_o, 1'b1);
        flush_bp_i = 1'b1;
        tick();
        flush_bp_i = 1'b0;
        vpc_i = 64'h1000;
        for (int i = 0; i < 200; i++) tick();
        lookup_valid_i = 1'b1; spec_branch_i = 1'b1; spec_taken_i = 1'b1;
        upd(64'h1000, 1'b1, 1'b1, 8'h00);
        lookup_valid_i = 1'b0; spec_branch_i = 1'b0; spec_taken_i = 1'b0;
        chk("init_ghr_held", ghr_o, 8'h00);
        count_busy(n, sv);
        chk("restart_cycles", n + 201, 512);
        chk("restart_no_pred", sv, 1'b0);
        chk("post_flush_valid", pred_valid_o, 2'b00);
        chk("post_flush_taken", pred_taken_o, 2'b11);
        chk("post_flush_ghr", ghr_o, 8'h00);
        vpc_i = 64'h1004;
        #1;
        chk("post_flush_row1", pred_valid_o, 2'b00);
        chk("post_flush_dut3", pred_valid3_o, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
